// File: rtl/mic_array_frame_packer.sv
// Mic array frame packer: collects one angle per mic pair and
// streams a framed, checksummed packet byte by byte to the UART.
module mic_array_frame_packer #(
  parameter int          NPAIR       = 4,
  parameter int          DW          = 16,
  parameter int          TIMEOUT_CYC = 60000,
  parameter logic [7:0]  SYNC0       = 8'hA5,
  parameter logic [7:0]  SYNC1       = 8'h5A
) (
  input  logic                clk_60MHz,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [NPAIR-1:0]    res_valid,
  input  logic [NPAIR*DW-1:0] res_angle,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                frame_done,
  output logic                overwrite_err
);

  localparam int NB = 5 + 2 * NPAIR;
  localparam int IW = 5;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] ILAST = IW'(NB - 1);

  typedef enum logic [1:0] {
    S_COLLECT,
    S_SNAP,
    S_SEND
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [DW-1:0]     r_slot [NPAIR];
  logic [NPAIR-1:0]  r_full;
  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_shd [NPAIR];
  logic [NPAIR-1:0]  r_shd_mask;
  logic [7:0]        r_seq;
  logic [IW-1:0]     r_idx;
  logic              r_done;
  logic              r_ovw;

  logic              w_snap;
  logic              w_send;
  logic              w_accept;
  logic              w_last;
  logic              w_start;
  logic [7:0]        w_mask8;
  logic [15:0]       w_ext [NPAIR];
  logic [7:0]        w_chk;
  logic [7:0]        w_ang;
  logic [7:0]        w_byte;

  assign w_snap   = (r_state == S_SNAP);
  assign w_send   = (r_state == S_SEND);
  assign w_accept = w_send && tx_ready;
  assign w_last   = (r_idx == ILAST);
  assign w_start  = ena && (|r_full) &&
                    ((&r_full) || (r_cnt == CMAX));

  // State register
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) r_state <= S_COLLECT;
    else        r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next   = r_state;
    tx_valid = 1'b0;
    busy     = 1'b0;
    unique case (r_state)
      S_COLLECT: if (w_start) w_next = S_SNAP;
      S_SNAP:    w_next = S_SEND;
      S_SEND: begin
        tx_valid = 1'b1;
        busy     = 1'b1;
        if (tx_ready && w_last) w_next = S_COLLECT;
      end
      default:   w_next = S_COLLECT;
    endcase
  end

  // Live slot storage; a strobe always writes its slot
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPAIR; k++) r_slot[k] <= '0;
    end else begin
      for (int k = 0; k < NPAIR; k++)
        if (res_valid[k]) r_slot[k] <= res_angle[k*DW +: DW];
    end
  end

  // Fill flags; SNAP empties them but keeps same-cycle strobes
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n)      r_full <= '0;
    else if (w_snap) r_full <= res_valid;
    else             r_full <= r_full | res_valid;
  end

  // Timeout counter, running from the first fill of an empty set
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n)               r_cnt <= '0;
    else if (w_snap)          r_cnt <= '0;
    else if (r_full == '0)    r_cnt <= '0;
    else if (r_cnt != CMAX)   r_cnt <= r_cnt + 1'b1;
  end

  // Overwrite pulse; SNAP-cycle strobes hit cleared slots
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) r_ovw <= 1'b0;
    else        r_ovw <= !w_snap && |(res_valid & r_full);
  end

  // Shadow copy of the frame; empty slots send zero
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NPAIR; k++) r_shd[k] <= '0;
      r_shd_mask <= '0;
    end else if (w_snap) begin
      for (int k = 0; k < NPAIR; k++)
        r_shd[k] <= r_full[k] ? r_slot[k] : '0;
      r_shd_mask <= r_full;
    end
  end

  // Byte index, sequence number and end-of-frame pulse
  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_seq  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_accept && w_last;
      if (w_snap) begin
        r_idx <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_idx <= '0;
          r_seq <= r_seq + 8'd1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  // Sign extension, mask byte and checksum from the shadow
  always_comb begin
    w_mask8 = '0;
    w_mask8[NPAIR-1:0] = r_shd_mask;
    w_chk = r_seq ^ w_mask8;
    for (int k = 0; k < NPAIR; k++) begin
      w_ext[k] = 16'($signed(r_shd[k]));
      w_chk = w_chk ^ w_ext[k][15:8] ^ w_ext[k][7:0];
    end
  end

  // Angle byte selected by the current index
  always_comb begin
    w_ang = '0;
    for (int k = 0; k < NPAIR; k++) begin
      if (r_idx == IW'(4 + 2 * k)) w_ang = w_ext[k][15:8];
      if (r_idx == IW'(5 + 2 * k)) w_ang = w_ext[k][7:0];
    end
  end

  // Outgoing byte multiplexer
  always_comb begin
    w_byte = '0;
    unique case (1'b1)
      (r_idx == IW'(0)): w_byte = SYNC0;
      (r_idx == IW'(1)): w_byte = SYNC1;
      (r_idx == IW'(2)): w_byte = r_seq;
      (r_idx == IW'(3)): w_byte = w_mask8;
      (r_idx == ILAST):  w_byte = w_chk;
      default:           w_byte = w_ang;
    endcase
  end

  assign tx_data       = w_send ? w_byte : 8'h00;
  assign frame_done    = r_done;
  assign overwrite_err = r_ovw;

endmodule

// File: tb/tb_mic_array_frame_packer.sv
// Scoreboard bench for mic_array_frame_packer: stimulus queues
// expected bytes, a negedge monitor pops and compares them.
module tb_mic_array_frame_packer;

  localparam int NPAIR = 4;
  localparam int DW    = 16;
  localparam int TO    = 20;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b0;
  logic [NPAIR-1:0]  res_valid = '0;
  logic [NPAIR*DW-1:0] res_angle = '0;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b1;
  logic              busy;
  logic              frame_done;
  logic              overwrite_err;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_ovw = 0;

  mic_array_frame_packer #(
    .NPAIR(NPAIR), .DW(DW), .TIMEOUT_CYC(TO),
    .SYNC0(8'hA5), .SYNC1(8'h5A)
  ) dut (
    .clk_60MHz(clk), .rst_n(rst_n), .ena(ena),
    .res_valid(res_valid), .res_angle(res_angle),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done),
    .overwrite_err(overwrite_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] seq,
                            input logic [3:0] m,
                            input logic [15:0] a0,
                            input logic [15:0] a1,
                            input logic [15:0] a2,
                            input logic [15:0] a3);
    logic [7:0] by [13];
    logic [7:0] c;
    by[0] = 8'hA5; by[1] = 8'h5A;
    by[2] = seq;   by[3] = {4'h0, m};
    by[4] = a0[15:8]; by[5]  = a0[7:0];
    by[6] = a1[15:8]; by[7]  = a1[7:0];
    by[8] = a2[15:8]; by[9]  = a2[7:0];
    by[10] = a3[15:8]; by[11] = a3[7:0];
    c = 8'h00;
    for (int i = 2; i < 12; i++) c = c ^ by[i];
    by[12] = c;
    for (int i = 0; i < 13; i++)
      q.push_back('{b: by[i], last: (i == 12)});
  endtask

  task automatic strobe(input logic [3:0] m,
                        input logic [15:0] a0,
                        input logic [15:0] a1,
                        input logic [15:0] a2,
                        input logic [15:0] a3);
    res_valid = m;
    res_angle = {a3, a2, a1, a0};
    tick();
    res_valid = '0;
  endtask

  task automatic wait_done(input int base, input bit rnd);
    int n;
    n = 0;
    while (n_done <= base && n < 2000) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tx_ready = 1'b1;
    if (n >= 2000) begin
      n_chk++;
      n_err++;
      $display("FAIL wait_done: timeout got %0d expected %0d",
               n_done, base + 1);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!tx_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard monitor
  initial begin
    bit pv;
    bit plast;
    logic [7:0] pd;
    exp_t e;
    pv = 0; plast = 0; pd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0;
        plast = 0;
      end else begin
        if (pv && tx_valid) check("hold", 16'(tx_data), 16'(pd));
        if (plast || frame_done)
          check("frame_done", 16'(frame_done), 16'(plast));
        if (overwrite_err) n_ovw++;
        if (frame_done) n_done++;
        plast = 0;
        if (tx_valid && tx_ready) begin
          n_acc++;
          if (q.size() == 0) begin
            check("extra_byte", 16'(tx_data), 16'hxxxx);
          end else begin
            e = q.pop_front();
            check("byte", 16'(tx_data), 16'(e.b));
            plast = e.last;
          end
        end
        pv = tx_valid && !tx_ready;
        pd = tx_data;
      end
    end
  end

  initial begin
    int lat;
    int b0;
    int bd;
    bit seen;

    repeat (3) tick();
    check("rst_tx_data", 16'(tx_data), 16'h0);
    check("rst_tx_valid", 16'(tx_valid), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_frame_done", 16'(frame_done), 16'h0);
    check("rst_ovw", 16'(overwrite_err), 16'h0);
    rst_n = 1'b1;
    ena = 1'b1;
    tick();

    // 1: full frame, back-to-back
    push_frame(8'h00, 4'hF, 16'h0001, 16'hFFFF,
               16'h0100, 16'h7FFF);
    b0 = n_acc; bd = n_done;
    strobe(4'hF, 16'h0001, 16'hFFFF, 16'h0100, 16'h7FFF);
    wait_valid(lat);
    check("lat_full", 16'(lat), 16'd2);
    check("sync0_first", 16'(tx_data), 16'hA5);
    check("busy_send", 16'(busy), 16'h1);
    wait_done(bd, 0);
    check("bytes_f1", 16'(n_acc - b0), 16'd13);
    check("busy_idle", 16'(busy), 16'h0);

    // 2: timeout with a single pair
    push_frame(8'h01, 4'h4, 16'h0, 16'h0, 16'h1234, 16'h0);
    bd = n_done;
    strobe(4'h4, 16'h0, 16'h0, 16'h1234, 16'h0);
    wait_valid(lat);
    check("lat_timeout", 16'(lat), 16'(TO + 1));
    wait_done(bd, 0);

    // 3: random back-pressure
    push_frame(8'h02, 4'hF, 16'hABCD, 16'h0042,
               16'h8001, 16'h1357);
    b0 = n_acc; bd = n_done;
    strobe(4'hF, 16'hABCD, 16'h0042, 16'h8001, 16'h1357);
    wait_done(bd, 1);
    check("bytes_rand", 16'(n_acc - b0), 16'd13);
    check("q_empty3", 16'(q.size()), 16'd0);

    // 4/5: overwrite, ena hold, SNAP-cycle strobe
    ena = 1'b0;
    b0 = n_ovw;
    strobe(4'h2, 16'h0, 16'h1111, 16'h0, 16'h0);
    strobe(4'h2, 16'h0, 16'h2222, 16'h0, 16'h0);
    strobe(4'hD, 16'h0A0A, 16'h0, 16'hF00F, 16'h5555);
    for (int i = 0; i < 5; i++) begin
      check("ena0_idle", 16'(tx_valid), 16'h0);
      tick();
    end
    check("ovw_once", 16'(n_ovw - b0), 16'd1);
    push_frame(8'h03, 4'hF, 16'h0A0A, 16'h2222,
               16'hF00F, 16'h5555);
    push_frame(8'h04, 4'h2, 16'h0, 16'h3333, 16'h0, 16'h0);
    bd = n_done;
    ena = 1'b1;
    tick();
    check("ena_snap", 16'(tx_valid), 16'h0);
    res_valid = 4'h2;
    res_angle = {16'h0, 16'h0, 16'h3333, 16'h0};
    tick();
    res_valid = '0;
    check("ena_sync0_v", 16'(tx_valid), 16'h1);
    check("ena_sync0_d", 16'(tx_data), 16'hA5);
    wait_done(bd, 0);
    wait_done(bd + 1, 0);
    check("ovw_snap", 16'(n_ovw - b0), 16'd1);

    // 5: run to seq wrap (frame 257 carries seq 0)
    for (int i = 5; i < 257; i++) begin
      logic [15:0] v;
      v = 16'(i);
      push_frame(v[7:0], 4'hF, v, ~v, v * 16'd3,
                 16'h8000 | v);
      bd = n_done;
      strobe(4'hF, v, ~v, v * 16'd3, 16'h8000 | v);
      wait_done(bd, 0);
    end
    check("q_empty_wrap", 16'(q.size()), 16'd0);

    // 6: reset during byte 5
    push_frame(8'h01, 4'hF, 16'h1111, 16'h2222,
               16'h3333, 16'h4444);
    b0 = n_acc;
    strobe(4'hF, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    lat = 0;
    while (n_acc < b0 + 5 && lat < 200) begin
      tick();
      lat++;
    end
    check("pre_rst_valid", 16'(tx_valid), 16'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", 16'(tx_valid), 16'h0);
    check("rst_mid_busy", 16'(busy), 16'h0);
    check("rst_mid_data", 16'(tx_data), 16'h0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < TO + 10; i++) begin
      tick();
      if (tx_valid) seen = 1;
    end
    check("slots_empty", 16'(seen), 16'h0);
    push_frame(8'h00, 4'hF, 16'h0102, 16'h0304,
               16'h0506, 16'h0708);
    bd = n_done;
    strobe(4'hF, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
    wait_done(bd, 0);
    tick();
    check("q_empty_end", 16'(q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
